// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC stage that follows the DDS generator.
// Holds the state encoding of the enable/drain state machine and the default
// sample width / prescale constants that the DDS and its bench also use.
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_t;

  // Default sample width (and PWM period counter width): period = 2^WIDTH ticks.
  localparam int PWM_WIDTH    = 8;
  // Default number of clock cycles per PWM tick.
  localparam int PWM_PRESCALE = 1;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescale counter for the PWM DAC.
// Counts 0..PRESCALE-1 and flags the last count as a tick.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   clear - synchronous restart of the count at 0 (period start / idle)
//   tick  - high during the cycle the count sits at PRESCALE-1
module pwm_tick_gen
  import pwm_dac_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // With PRESCALE=1 the counter degenerates to a single bit stuck at 0,
  // which makes tick permanently high (one tick per clock).
  localparam int               CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]    LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: turns the unsigned DDS sample stream into a single-bit PWM
// waveform for an external RC low-pass filter.
// One sample is latched per PWM period (2^WIDTH ticks of PRESCALE cycles)
// and attenuated by a logical right shift. An enable/drain state machine
// makes sure a started period always runs to completion.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   en           - run request
//   DDS_in       - unsigned sample from the DDS
//   Amp_cntrl    - attenuation, duty = DDS_in >> Amp_cntrl
//   PWM_out      - modulated output (registered, glitch-free)
//   Period_start - one-cycle pulse on the first cycle of each period
//   Busy         - high whenever the state machine is not idle
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int PRESCALE = PWM_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] DDS_in,
  input  logic [1:0]       Amp_cntrl,
  output logic             PWM_out,
  output logic             Period_start,
  output logic             Busy
);

  pwm_state_t       r_state;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_cnt;
  logic             r_period_start;
  logic             r_busy;
  logic             r_pwm;

  pwm_state_t       w_state_next;
  logic [WIDTH-1:0] w_duty_next;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_tick;
  logic             w_period_end;
  logic             w_start;
  logic             w_clear;

  // The prescaler is held at 0 while idle and restarted on every period
  // start so the first tick of a period lands exactly PRESCALE cycles in.
  assign w_clear = w_start || (r_state == ST_IDLE);

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  assign w_period_end = (r_state != ST_IDLE) && w_tick && (r_cnt == {WIDTH{1'b1}});

  // A period ending in RUN always launches the next one, even if en has
  // just dropped: that extra period is then drained in full. In DRAIN a
  // new period only follows if en is back.
  assign w_start = ((r_state == ST_IDLE)  && en) ||
                   ((r_state == ST_RUN)   && w_period_end) ||
                   ((r_state == ST_DRAIN) && en && w_period_end);

  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    w_cnt_next   = r_cnt;

    case (r_state)
      ST_IDLE:  if (en) w_state_next = ST_RUN;
      ST_RUN:   if (!en) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                w_state_next = ST_RUN;
        else if (w_period_end) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase

    if (w_start) begin
      w_duty_next = DDS_in >> Amp_cntrl;
      w_cnt_next  = '0;
    end else if (r_state == ST_IDLE) begin
      w_cnt_next = '0;
    end else if (w_tick) begin
      w_cnt_next = r_cnt + 1'b1;  // wraps to 0 at period end
    end
  end

  // Outputs are computed from next-state values and registered, so they
  // line up with the counters yet never glitch into the RC filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_duty         <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
      r_busy         <= 1'b0;
      r_pwm          <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_duty         <= w_duty_next;
      r_cnt          <= w_cnt_next;
      r_period_start <= w_start;
      r_busy         <= (w_state_next != ST_IDLE);
      r_pwm          <= (w_state_next != ST_IDLE) && (w_cnt_next < w_duty_next);
    end
  end

  assign PWM_out      = r_pwm;
  assign Period_start = r_period_start;
  assign Busy         = r_busy;

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Downstream stage of the DDS generator. Converts the 8-bit `DDS_out` sample stream into a single-bit PWM waveform for an external RC low-pass filter acting as the analog DAC. Latches one sample per PWM period and applies a selectable power-of-two attenuation. An enable/drain state machine guarantees that no period is ever truncated.

## Interface
- `WIDTH`, default 8: sample width and PWM period counter width; the period is 2^WIDTH ticks.
- `PRESCALE`, default 1: clock cycles per PWM tick; must be ≥1.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run request.
- `DDS_in` in WIDTH: unsigned sample, connected to `DDS_out`.
- `Amp_cntrl` in 2: attenuation; the effective duty is `DDS_in >> Amp_cntrl`.
- `PWM_out` out 1: modulated output.
- `Period_start` out 1: one-cycle pulse on the first cycle of each period.
- `Busy` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: counters held at 0; `PWM_out` = 0.
  - RUN: periods repeat back-to-back.
  - DRAIN: finishes the current period, then stops.
- Transitions:
  - IDLE→RUN on the edge where `en`=1.
  - RUN→DRAIN on the edge where `en`=0.
  - DRAIN→RUN on the edge where `en`=1; the current period continues undisturbed.
  - DRAIN→IDLE at the end of the current period.
- Period start:
  - Occurs on the IDLE→RUN edge, and on every period-end edge while in RUN.
  - On that edge, `duty` ← `DDS_in >> Amp_cntrl`, using both inputs as sampled at that edge.
  - The tick counter and period counter reset to 0 on the same edge.
- Tick counter: counts 0..PRESCALE-1 and emits a tick on PRESCALE-1. The period counter `cnt` advances on each tick and wraps from 2^WIDTH-1 to 0; the wrap marks the period end.
- Output rule: `PWM_out` = 1 iff state ∈ {RUN, DRAIN} and `cnt` < `duty`.
- Duty extremes:
  - `duty`=0 → output constantly low.
  - `duty`=2^WIDTH-1 → output high for all but one tick per period.
- Changes on `DDS_in` or `Amp_cntrl` mid-period are ignored until the next period start.
- All arithmetic is unsigned. The shift is logical and zero-fills; no rounding.

## Timing
- Reset values: `PWM_out`=0, `Period_start`=0, `Busy`=0, state=IDLE, `duty`=0, all counters 0.
- Period length: exactly 2^WIDTH·PRESCALE clock cycles.
- `Period_start` is high on the first cycle of each period, i.e. the cycle after the latching edge.
- `PWM_out` is high on exactly `duty`·PRESCALE consecutive cycles, beginning in the same cycle as `Period_start`, then low for the remainder of the period.
- Latency: the sample present before edge E is reflected on `PWM_out` in the cycle starting at E.
- `Busy` rises with the first `Period_start` cycle.
- `Busy` falls in the cycle after the last cycle of the drained period; `PWM_out` is 0 from that cycle onward.
- Simultaneous period end with `en`=0 in RUN: the period ends, RUN→DRAIN occurs, and a new period is started and drained. The result is one full extra period, never a partial one.
- `rst` mid-period: all outputs go to 0 immediately, without waiting for a clock edge. After release, operation restarts from IDLE.

## Structure
- The shared header defines:
  - the state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the default WIDTH and PRESCALE constants, shared with the DDS and its bench.
- Sub-module `pwm_tick_gen` holds the prescale counter. It takes clk, rst, and a clear input, and outputs a 1-cycle `tick`.
- The top level holds the FSM, the `duty` latch, the period counter, and the output compare.

## Test plan
All scenarios use WIDTH=8 and PRESCALE=1 unless stated otherwise.
- Reset: assert `rst` with `en`=1 and `DDS_in`=8'hFF → `PWM_out`=0, `Period_start`=0, `Busy`=0 throughout.
- `DDS_in`=64, `Amp_cntrl`=0, `en`=1 → `Period_start` every 256 cycles; `PWM_out` high 64 cycles, then low 192 cycles.
- `DDS_in`=200, `Amp_cntrl`=2 → 50 cycles high per period. Toggling `DDS_in` to 10 mid-period changes nothing until the next `Period_start`.
- Extremes: `DDS_in`=0 → no high cycles. `DDS_in`=255 → 255 cycles high, 1 low.
- Drain: `DDS_in`=128; drop `en` at cycle 100 of the period → the period completes (128 high/128 low), then `Busy`=0. Re-raising `en` at cycle 200 → the next period starts back-to-back.
- PRESCALE=4, `DDS_in`=10 → period 1024 cycles, 40 high. Assert `rst` at cycle 20 → `PWM_out`=0 asynchronously; the first `Period_start` after `en` comes exactly one cycle after re-enable.
